// File: rtl/hamming74_pkg.sv
// Shared types and framing constants for the Hamming(7,4) receive path.
package hamming74_pkg;

  localparam int FRAME_BITS = 14;
  localparam int CW_BITS    = FRAME_BITS / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CW0  = 2'd1,
    CW1  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/Hamming74_Decoder.sv
// Single-error-correcting Hamming(7,4) decoder; data_in[i] is codeword position i+1,
// parity at positions 1,2,4 and data nibble at positions 3,5,6,7 (LSB first).
module Hamming74_Decoder (
  input  logic [6:0] data_in,
  output logic [3:0] data_out,
  output logic       err
);

  logic [2:0] w_syn;

  // The syndrome equals the 1-based position of a single flipped bit.
  assign w_syn[0] = data_in[0] ^ data_in[2] ^ data_in[4] ^ data_in[6];
  assign w_syn[1] = data_in[1] ^ data_in[2] ^ data_in[5] ^ data_in[6];
  assign w_syn[2] = data_in[3] ^ data_in[4] ^ data_in[5] ^ data_in[6];

  assign data_out = {data_in[6] ^ (w_syn == 3'd7),
                     data_in[5] ^ (w_syn == 3'd6),
                     data_in[4] ^ (w_syn == 3'd5),
                     data_in[2] ^ (w_syn == 3'd3)};
  assign err      = |w_syn;

endmodule

// File: rtl/hamming74_rx_ctrl.sv
// Bit-serial Hamming(7,4) frame receiver: deserialises two codewords per frame through
// one shared decoder and presents the corrected byte on a valid/ready output.
module hamming74_rx_ctrl
  import hamming74_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  input  logic                 frame_start,
  input  logic                 clr_stats,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic [7:0]           byte_data,
  output logic                 byte_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overflow,
  output logic                 rx_busy
);

  localparam logic [2:0] LAST_IDX = 3'(CW_BITS - 1);

  rx_state_t            r_state, w_state_nxt;
  logic [2:0]           r_bit_cnt;
  logic [5:0]           r_shreg;
  logic [3:0]           r_hi_nib;
  logic                 r_hi_err;
  logic                 r_rx_busy;
  logic                 r_byte_valid;
  logic [7:0]           r_byte_data;
  logic                 r_byte_err;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic                 r_overflow;

  logic                 w_start, w_in_frame, w_cw_done, w_frame_done, w_slot_free;
  logic [3:0]           w_dec_nib;
  logic                 w_dec_err;
  logic [1:0]           w_err_sum;
  logic [ERR_CNT_W:0]   w_cnt_sum;
  logic [ERR_CNT_W-1:0] w_cnt_sat;

  Hamming74_Decoder u_dec (
    .data_in  ({ser_data, r_shreg}),
    .data_out (w_dec_nib),
    .err      (w_dec_err)
  );

  // A frame_start bit always restarts framing, so it can never complete a codeword.
  assign w_start      = ser_valid & frame_start;
  assign w_in_frame   = (r_state != IDLE);
  assign w_cw_done    = ser_valid & ~frame_start & w_in_frame & (r_bit_cnt == LAST_IDX);
  assign w_frame_done = w_cw_done & (r_state == CW1);
  assign w_slot_free  = ~r_byte_valid | byte_ready;

  assign w_err_sum = {1'b0, r_hi_err} + {1'b0, w_dec_err};
  assign w_cnt_sum = {1'b0, r_err_count} + (ERR_CNT_W + 1)'(w_err_sum);
  assign w_cnt_sat = w_cnt_sum[ERR_CNT_W] ? '1 : w_cnt_sum[ERR_CNT_W-1:0];

  always_comb begin
    // NOTE: default assignment first so every path drives w_state_nxt (no latch).
    w_state_nxt = r_state;
    if (w_start)
      w_state_nxt = CW0;
    else if (w_cw_done)
      w_state_nxt = (r_state == CW0) ? CW1 : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rx_busy <= 1'b0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_hi_nib  <= '0;
      r_hi_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state   <= w_state_nxt;
      r_rx_busy <= (w_state_nxt != IDLE);
      if (ser_valid && (frame_start || w_in_frame)) begin
        r_shreg <= {ser_data, r_shreg[5:1]};
        if (w_start)
          r_bit_cnt <= 3'd1;
        else if (w_cw_done)
          r_bit_cnt <= '0;
        else
          r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_cw_done && (r_state == CW0)) begin
        r_hi_nib <= w_dec_nib;
        r_hi_err <= w_dec_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_byte_err   <= 1'b0;
      r_err_count  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_frame_done && w_slot_free) begin
        r_byte_valid <= 1'b1;
        r_byte_data  <= {r_hi_nib, w_dec_nib};
        r_byte_err   <= r_hi_err | w_dec_err;
      end else if (r_byte_valid && byte_ready) begin
        r_byte_valid <= 1'b0;
      end
      // Statistics count every completed frame, dropped or not; a clear overrides.
      if (clr_stats) begin
        r_err_count <= '0;
        r_overflow  <= 1'b0;
      end else if (w_frame_done) begin
        r_err_count <= w_cnt_sat;
        if (!w_slot_free)
          r_overflow <= 1'b1;
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign byte_err   = r_byte_err;
  assign err_count  = r_err_count;
  assign overflow   = r_overflow;
  assign rx_busy    = r_rx_busy;

endmodule
